// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// Mode, FSM state and multi-shift direction encodings.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_MULTI = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_next_value.sv
// Next-value mux for the single-cycle register modes.
// Multi-shift is handled by the top; here it simply holds.
module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  mode_e            mode_i,
  input  logic             ser_in_msb_i,
  input  logic             ser_in_lsb_i,
  input  logic [WIDTH-1:0] par_in_i,
  output logic [WIDTH-1:0] q_d_o
);

  // Select the next register value for one command edge
  always_comb begin
    q_d_o = q_i;
    unique case (mode_i)
      MODE_HOLD:  q_d_o = q_i;
      MODE_SHR:   q_d_o = {ser_in_msb_i, q_i[WIDTH-1:1]};
      MODE_SHL:   q_d_o = {q_i[WIDTH-2:0], ser_in_lsb_i};
      MODE_ROR:   q_d_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:   q_d_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_LOAD:  q_d_o = par_in_i;
      MODE_ASR:   q_d_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_MULTI: q_d_o = q_i;
      default:    q_d_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with multi-cycle shift-by-N.
// Define USR_PARITY_EN to add an even-parity output of q.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  input  logic [WIDTH-1:0] par_in,
  input  logic [AW-1:0]    amount,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shifted;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    amt_sat;
  logic             dir_q;
  logic             shift_dir;
  logic             done_q;
  state_e           state_q;
  mode_e            mode_c;

  assign mode_c = mode_e'(mode);

  usr_next_value #(
    .WIDTH(WIDTH)
  ) u_next (
    .q_i         (q_q),
    .mode_i      (mode_c),
    .ser_in_msb_i(ser_in_msb),
    .ser_in_lsb_i(ser_in_lsb),
    .par_in_i    (par_in),
    .q_d_o       (q_nxt)
  );

  // Clamp the shift count and build the zero-filled single step
  always_comb begin
    amt_sat   = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;
    shift_dir = (state_q == ST_SHIFT) ? dir_q : dir;
    shifted   = (shift_dir == DIR_LEFT) ?
                {q_q[WIDTH-2:0], 1'b0} :
                {1'b0, q_q[WIDTH-1:1]};
  end

  // Register, multi-shift FSM, counter and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      done_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (en) begin
            if (mode_c == MODE_MULTI) begin
              dir_q <= dir;
              if (amt_sat == '0) begin
                done_q <= 1'b1;
              end else begin
                q_q   <= shifted;
                cnt_q <= amt_sat - AW'(1);
                if (amt_sat == AW'(1)) begin
                  done_q <= 1'b1;
                end else begin
                  state_q <= ST_SHIFT;
                end
              end
            end else begin
              q_q <= q_nxt;
            end
          end
        end
        ST_SHIFT: begin
          q_q   <= shifted;
          cnt_q <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign q           = q_q;
  assign ser_out_msb = q_q[WIDTH-1];
  assign ser_out_lsb = q_q[0];
  assign busy        = (state_q == ST_SHIFT);
  assign done        = done_q;

`ifdef USR_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register at WIDTH=8.
// Directed vectors plus a cycle-by-cycle reference model.
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic          ser_in_msb;
  logic          ser_in_lsb;
  logic [W-1:0]  par_in;
  logic [AW-1:0] amount;
  logic          dir;
  logic [W-1:0]  q;
  logic          ser_out_msb;
  logic          ser_out_lsb;
  logic          busy;
  logic          done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  universal_shift_register #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .ser_in_msb (ser_in_msb),
    .ser_in_lsb (ser_in_lsb),
    .par_in     (par_in),
    .amount     (amount),
    .dir        (dir),
    .q          (q),
    .ser_out_msb(ser_out_msb),
    .ser_out_lsb(ser_out_lsb),
    .busy       (busy),
    .done       (done)
`ifdef USR_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: value arithmetic plus a remaining-shift count
  logic [W-1:0] mq;
  int           rem;
  logic         mdir;
  logic         mdone;
  int           k;

  always @(posedge clk) begin
    if (rst) begin
      mq    = '0;
      rem   = 0;
      mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (rem > 0) begin
        mq  = mdir ? W'(mq << 1) : W'(mq >> 1);
        rem = rem - 1;
        if (rem == 0) mdone = 1'b1;
      end else if (en) begin
        case (mode)
          3'd1: mq = W'(mq >> 1) | W'(ser_in_msb ? 8'h80 : 8'h00);
          3'd2: mq = W'(mq << 1) | W'(ser_in_lsb);
          3'd3: mq = W'(mq >> 1) | W'(mq[0] ? 8'h80 : 8'h00);
          3'd4: mq = W'(mq << 1) | W'(mq >> 7);
          3'd5: mq = par_in;
          3'd6: mq = W'(mq >> 1) | (mq & 8'h80);
          3'd7: begin
            k = (int'(amount) > W) ? W : int'(amount);
            if (k == 0) begin
              mdone = 1'b1;
            end else begin
              mdir = dir;
              mq   = dir ? W'(mq << 1) : W'(mq >> 1);
              rem  = k - 1;
              if (rem == 0) mdone = 1'b1;
            end
          end
          default: mq = mq;
        endcase
      end
    end
    #1;
    chk("model_q", 32'(q), 32'(mq));
    chk("model_busy", 32'(busy), 32'(rem > 0));
    chk("model_done", 32'(done), 32'(mdone));
    chk("model_msb", 32'(ser_out_msb), 32'(mq[W-1]));
    chk("model_lsb", 32'(ser_out_lsb), 32'(mq[0]));
`ifdef USR_PARITY_EN
    chk("model_parity", 32'(parity), 32'(^mq));
`endif
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [2:0] m,
                       input logic [W-1:0] p);
    en     = e;
    mode   = m;
    par_in = p;
  endtask

  task automatic multi(input logic [AW-1:0] a, input logic d);
    en     = 1'b1;
    mode   = 3'b111;
    amount = a;
    dir    = d;
  endtask

  logic [7:0] msb_seq;

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    mode       = 3'b000;
    ser_in_msb = 1'b0;
    ser_in_lsb = 1'b0;
    par_in     = '0;
    amount     = '0;
    dir        = 1'b0;
    msb_seq    = 8'b1000_0001;
    tick();
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);

    // Reset while a load is presented
    rst = 1'b0;
    drive(1'b1, 3'b101, 8'hB4);
    tick();
    chk("load_b4", 32'(q), 32'hB4);
    rst = 1'b1;
    drive(1'b1, 3'b101, 8'h55);
    tick();
    chk("rst_over_load_q", 32'(q), 32'h00);
    chk("rst_over_load_done", 32'(done), 32'h0);

    // Reset in the middle of a multi-shift
    rst = 1'b0;
    drive(1'b1, 3'b101, 8'hF0);
    tick();
    multi(4'd5, 1'b0);
    tick();
    chk("mid_busy", 32'(busy), 32'h1);
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_q", 32'(q), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_nodone", 32'(done), 32'h0);

    // Single-cycle modes
    drive(1'b1, 3'b101, 8'hB4);
    tick();
    drive(1'b1, 3'b011, 8'h00);
    tick();
    chk("ror", 32'(q), 32'h5A);
    drive(1'b1, 3'b100, 8'h00);
    tick();
    chk("rol", 32'(q), 32'hB4);
    drive(1'b1, 3'b110, 8'h00);
    tick();
    chk("asr", 32'(q), 32'hDA);
    ser_in_msb = 1'b0;
    drive(1'b1, 3'b001, 8'h00);
    tick();
    chk("shr", 32'(q), 32'h6D);
    drive(1'b0, 3'b101, 8'h33);
    tick();
    chk("en_low_hold", 32'(q), 32'h6D);

    // Serial fill from the LSB
    drive(1'b1, 3'b101, 8'h81);
    tick();
    ser_in_lsb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("shl_msb_seq", 32'(ser_out_msb), 32'(msb_seq[7-i]));
      drive(1'b1, 3'b010, 8'h00);
      tick();
    end
    chk("shl_fill", 32'(q), 32'hFF);
    ser_in_lsb = 1'b0;

    // Multi-shift right by 3, load attempted while busy
    drive(1'b1, 3'b101, 8'hF0);
    tick();
    multi(4'd3, 1'b0);
    tick();
    chk("m3_e1_q", 32'(q), 32'h78);
    chk("m3_e1_busy", 32'(busy), 32'h1);
    drive(1'b1, 3'b101, 8'hAA);
    tick();
    chk("m3_e2_q", 32'(q), 32'h3C);
    chk("m3_e2_busy", 32'(busy), 32'h1);
    tick();
    chk("m3_e3_q", 32'(q), 32'h1E);
    chk("m3_e3_busy", 32'(busy), 32'h0);
    chk("m3_e3_done", 32'(done), 32'h1);
    drive(1'b1, 3'b101, 8'h3C);
    tick();
    chk("accept_on_done", 32'(q), 32'h3C);
    chk("done_one_cycle", 32'(done), 32'h0);

    // Multi-shift by zero
    drive(1'b1, 3'b101, 8'h5A);
    tick();
    multi(4'd0, 1'b1);
    tick();
    chk("m0_q", 32'(q), 32'h5A);
    chk("m0_done", 32'(done), 32'h1);
    chk("m0_busy", 32'(busy), 32'h0);

    // Multi-shift by one
    multi(4'd1, 1'b1);
    tick();
    chk("m1_q", 32'(q), 32'hB4);
    chk("m1_done", 32'(done), 32'h1);

    // Oversized amount clamps to full width
    drive(1'b1, 3'b101, 8'hFF);
    tick();
    multi(4'd15, 1'b1);
    tick();
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("m15_e7_q", 32'(q), 32'h80);
    chk("m15_e7_busy", 32'(busy), 32'h1);
    tick();
    chk("m15_q", 32'(q), 32'h00);
    chk("m15_done", 32'(done), 32'h1);
    tick();

    // Multi-shift left by 2 ignores serial inputs
    ser_in_lsb = 1'b1;
    drive(1'b1, 3'b101, 8'h81);
    tick();
    multi(4'd2, 1'b1);
    tick();
    en = 1'b0;
    tick();
    chk("m2_left_q", 32'(q), 32'h04);
    ser_in_lsb = 1'b0;

`ifdef USR_PARITY_EN
    drive(1'b1, 3'b101, 8'h07);
    tick();
    chk("parity_07", 32'(parity), 32'h1);
    drive(1'b1, 3'b101, 8'h03);
    tick();
    chk("parity_03", 32'(parity), 32'h0);
`endif

    drive(1'b0, 3'b000, 8'h00);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
